// File: rtl/spi_frame_rx.sv
// SPI slave frame receiver: input synchronisers, frame assembly with length check, FWFT frame FIFO.
// Optional saturating error counter with err_clr/err_count ports when SPI_ERR_CNT_EN is defined.
module spi_frame_rx #(
    parameter int BYTES_PER_FRAME = 2,
    parameter int FIFO_DEPTH      = 4,
    parameter int SYNC_STAGES     = 2,
    parameter bit SAMPLE_RISE     = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sck,
    input  logic                         sdi,
    input  logic                         cs,
    output logic [8*BYTES_PER_FRAME-1:0] frame_data,
    output logic                         frame_valid,
    input  logic                         frame_ready,
    output logic                         busy,
    output logic                         err_short,
    output logic                         err_long,
`ifdef SPI_ERR_CNT_EN
    input  logic                         err_clr,
    output logic [7:0]                   err_count,
`endif
    output logic                         err_ovf
);
    localparam int FW = 8 * BYTES_PER_FRAME;
    localparam int CW = $clog2(FW + 2);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int WW = $clog2(SYNC_STAGES + 1);

    typedef enum logic {IDLE, RECV} state_e;

    logic [SYNC_STAGES-1:0] sck_sync_q, sdi_sync_q, cs_sync_q;
    logic                   sck_prev_q, cs_prev_q;
    logic [WW-1:0]          warm_q;
    logic                   armed_q;
    logic                   sck_s, sdi_s, cs_s;
    logic                   sck_rise, sck_fall, bit_stb, cs_fall, cs_rise;

    assign sck_s = sck_sync_q[SYNC_STAGES-1];
    assign sdi_s = sdi_sync_q[SYNC_STAGES-1];
    assign cs_s  = cs_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sck_sync_q <= '0;
            sdi_sync_q <= '0;
            cs_sync_q  <= '1;
            sck_prev_q <= 1'b0;
            cs_prev_q  <= 1'b1;
            warm_q     <= '0;
            armed_q    <= 1'b0;
        end else begin
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck};
            sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], sdi};
            cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], cs};
            sck_prev_q <= sck_s;
            cs_prev_q  <= cs_s;
            if (warm_q != WW'(SYNC_STAGES))
                warm_q <= warm_q + WW'(1);
            // Arm only once the synchronisers hold real pin values and cs has been seen high,
            // so a cs already low when reset releases does not start a frame.
            if (warm_q == WW'(SYNC_STAGES) && cs_s)
                armed_q <= 1'b1;
        end
    end

    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign bit_stb  = SAMPLE_RISE ? sck_rise : sck_fall;
    assign cs_fall  = armed_q & cs_prev_q & ~cs_s;
    assign cs_rise  = cs_s & ~cs_prev_q;
    assign busy     = ~cs_s;

    state_e         state_q;
    logic [FW-1:0]  shreg_q;
    logic [CW-1:0]  cnt_q;
    logic           long_q;
    logic           err_short_q, err_long_q, err_ovf_q;

    logic [FW-1:0]  mem_q [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic           frame_valid_q;
    logic [FW-1:0]  frame_data_q;
    logic           full, pop, push, eval_good;

    assign full      = (wr_ptr_q - rd_ptr_q) == PW'(FIFO_DEPTH);
    assign pop       = frame_valid_q & frame_ready;
    assign eval_good = (state_q == RECV) & cs_rise & (cnt_q == CW'(FW));
    assign push      = eval_good & (~full | pop);
    assign rd_ptr_d  = rd_ptr_q + PW'(pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            long_q      <= 1'b0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
            err_ovf_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_q <= RECV;
                        shreg_q <= '0;
                        cnt_q   <= '0;
                        long_q  <= 1'b0;
                    end
                end
                RECV: begin
                    if (cs_rise) begin
                        state_q     <= IDLE;
                        err_short_q <= cnt_q < CW'(FW);
                        err_long_q  <= long_q;
                        err_ovf_q   <= eval_good & full & ~pop;
                    end else if (bit_stb) begin
                        if (cnt_q < CW'(FW)) begin
                            shreg_q <= {shreg_q[FW-2:0], sdi_s};
                            cnt_q   <= cnt_q + CW'(1);
                        end else begin
                            long_q <= 1'b1;
                            cnt_q  <= CW'(FW + 1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q[AW-1:0]] <= shreg_q;
    end

    // Output register sees pushes one cycle late, which gives the fixed cs-to-valid latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            frame_valid_q <= 1'b0;
            frame_data_q  <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_q + PW'(push);
            rd_ptr_q      <= rd_ptr_d;
            frame_valid_q <= wr_ptr_q != rd_ptr_d;
            frame_data_q  <= (wr_ptr_q != rd_ptr_d) ? mem_q[rd_ptr_d[AW-1:0]] : '0;
        end
    end

    assign frame_valid = frame_valid_q;
    assign frame_data  = frame_data_q;
    assign err_short   = err_short_q;
    assign err_long    = err_long_q;
    assign err_ovf     = err_ovf_q;

`ifdef SPI_ERR_CNT_EN
    logic [7:0] err_count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            err_count_q <= '0;
        else if (err_clr)
            err_count_q <= '0;
        else if ((err_short_q | err_long_q | err_ovf_q) && err_count_q != 8'hFF)
            err_count_q <= err_count_q + 8'd1;
    end

    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed + randomized bench for spi_frame_rx against a queue-based frame model.
// Covers the error counter when SPI_ERR_CNT_EN is defined.
module tb_spi_frame_rx;
    localparam int FW    = 16;
    localparam int DEPTH = 4;

    logic clk = 1'b0, reset = 1'b0, sck = 1'b0, sdi = 1'b0, cs = 1'b1, frame_ready = 1'b0;
    logic [FW-1:0] frame_data;
    logic frame_valid, busy, err_short, err_long, err_ovf;
`ifdef SPI_ERR_CNT_EN
    logic err_clr = 1'b0;
    logic [7:0] err_count;
`endif

    int checks = 0, failures = 0;
    int n_short = 0, n_long = 0, n_ovf = 0;
    logic [FW-1:0] got[$];

    always #5 clk = ~clk;

    spi_frame_rx #(.BYTES_PER_FRAME(2), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2), .SAMPLE_RISE(1'b1)) dut (
        .clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .cs(cs),
        .frame_data(frame_data), .frame_valid(frame_valid), .frame_ready(frame_ready),
        .busy(busy), .err_short(err_short), .err_long(err_long),
`ifdef SPI_ERR_CNT_EN
        .err_clr(err_clr), .err_count(err_count),
`endif
        .err_ovf(err_ovf));

    // Event monitor: samples between input changes (negedge) and output changes (posedge).
    always @(negedge clk) begin
        #1;
        if (err_short) n_short++;
        if (err_long) n_long++;
        if (err_ovf) n_ovf++;
        if (frame_valid && frame_ready) got.push_back(frame_data);
    end

    initial begin
        #3000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pop(input string tag, input logic [FW-1:0] e);
        logic [FW-1:0] v;
        v = (got.size() > 0) ? got.pop_front() : 'x;
        chk(tag, {48'h0, v}, {48'h0, e});
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // cs low, n bits MSB first, 8-clk sck period; cs is left low.
    task automatic spi_bits(input logic [63:0] d, input int n);
        @(negedge clk);
        cs = 1'b0;
        clks(4);
        for (int i = n - 1; i >= 0; i--) begin
            sdi = d[i];
            clks(4);
            sck = 1'b1;
            clks(4);
            sck = 1'b0;
        end
        clks(4);
    endtask

    task automatic send(input logic [63:0] d, input int n);
        spi_bits(d, n);
        cs  = 1'b1;
        sdi = 1'b0;
        clks(10);
    endtask

    initial begin
        int s0, l0, o0, lat, vcyc, rdy, n, es, el, eo;
        logic [FW-1:0] vdata;
        logic [63:0] d;
        logic [7:0] b;
        logic [FW-1:0] model[$];
        logic [FW-1:0] expq[$];

        // Reset state, with cs held low across reset release
        cs = 1'b0;
        clks(3);
        chk("rst_valid", frame_valid, 0);
        chk("rst_data", frame_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_errs", {err_short, err_long, err_ovf}, 0);
`ifdef SPI_ERR_CNT_EN
        chk("rst_err_count", err_count, 0);
`endif
        reset = 1'b1;
        clks(10);
        chk("busy_cs_low_after_reset", busy, 1);
        cs = 1'b1;
        clks(10);
        chk("cs_low_at_reset_ignored", n_short, 0);
        chk("busy_idle", busy, 0);

        // Test 1: single frame, latency and 1-cycle valid
        frame_ready = 1'b1;
        spi_bits(64'hA53C, 16);
        chk("busy_in_frame", busy, 1);
        cs = 1'b1;
        lat = 0; vcyc = 0; vdata = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (frame_valid) begin
                if (lat == 0) begin lat = k; vdata = frame_data; end
                vcyc++;
            end
        end
        chk("t1_latency", lat, 4);
        chk("t1_valid_cycles", vcyc, 1);
        chk("t1_data", vdata, 16'hA53C);
        chk("t1_no_errs", n_short + n_long + n_ovf, 0);
        chk_pop("t1_pop", 16'hA53C);

        // Test 2: fill FIFO, overflow on 5th, then drain
        frame_ready = 1'b0;
        o0 = n_ovf; s0 = n_short;
        for (int i = 1; i <= 5; i++) begin
            b = i[7:0];
            send({48'h0, b, b}, 16);
        end
        chk("t2_ovf", n_ovf - o0, 1);
        chk("t2_no_short", n_short - s0, 0);
        chk("t2_valid", frame_valid, 1);
        chk("t2_head", frame_data, 16'h0101);
        frame_ready = 1'b1;
        clks(10);
        chk("t2_drained", frame_valid, 0);
        chk_pop("t2_pop1", 16'h0101);
        chk_pop("t2_pop2", 16'h0202);
        chk_pop("t2_pop3", 16'h0303);
        chk_pop("t2_pop4", 16'h0404);
        chk("t2_no_extra", got.size(), 0);

        // Test 3: length errors
        s0 = n_short; l0 = n_long;
        send(64'hABC, 12);
        chk("t3_short12", n_short - s0, 1);
        send(64'h1_5A5A, 17);
        chk("t3_long17", n_long - l0, 1);
        send(64'h0, 0);
        chk("t3_short0", n_short - s0, 2);
        chk("t3_fifo_unchanged", got.size(), 0);
        chk("t3_valid", frame_valid, 0);

        // Test 4: async reset mid-frame with FIFO occupied
        frame_ready = 1'b0;
        send(64'h7777, 16);
        chk("t4_prefill", frame_valid, 1);
        s0 = n_short; l0 = n_long; o0 = n_ovf;
        spi_bits(64'h1AB, 9);
        #3 reset = 1'b0;
        #1;
        chk("t4_rst_outs", {frame_valid, busy, err_short, err_long, err_ovf}, 0);
        chk("t4_rst_data", frame_data, 0);
        @(negedge clk);
        cs = 1'b1;
        sdi = 1'b0;
        clks(2);
        reset = 1'b1;
        clks(10);
        chk("t4_fifo_empty", frame_valid, 0);
        chk("t4_no_err", (n_short - s0) + (n_long - l0) + (n_ovf - o0), 0);
        frame_ready = 1'b1;
        send(64'h1234, 16);
        chk_pop("t4_after_reset", 16'h1234);
        chk("t4_only_one", got.size(), 0);

        // Test 5: pop in the same cycle as the evaluation of a frame into a full FIFO
        frame_ready = 1'b0;
        o0 = n_ovf;
        for (int i = 1; i <= 4; i++) send(64'hA000 + 64'(i), 16);
        spi_bits(64'hA005, 16);
        cs = 1'b1;
        clks(2);
        frame_ready = 1'b1;
        clks(1);
        frame_ready = 1'b0;
        clks(10);
        chk("t5_no_ovf", n_ovf - o0, 0);
        chk_pop("t5_popped_head", 16'hA001);
        send(64'hA006, 16);
        chk("t5_still_full", n_ovf - o0, 1);
        frame_ready = 1'b1;
        clks(10);
        chk_pop("t5_pop2", 16'hA002);
        chk_pop("t5_pop3", 16'hA003);
        chk_pop("t5_pop4", 16'hA004);
        chk_pop("t5_pop5", 16'hA005);
        chk("t5_no_extra", got.size(), 0);

        // Randomized frames against the queue model
        es = n_short; el = n_long; eo = n_ovf;
        for (int it = 0; it < 30; it++) begin
            rdy = int'($urandom_range(0, 1));
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : 16;
            d = {$urandom, $urandom};
            frame_ready = rdy[0];
            if (rdy != 0)
                while (model.size() > 0) expq.push_back(model.pop_front());
            if (n == FW) begin
                if (rdy != 0) expq.push_back(d[FW-1:0]);
                else if (model.size() < DEPTH) model.push_back(d[FW-1:0]);
                else eo++;
            end else if (n < FW) es++;
            else el++;
            send(d, n);
            chk("rnd_short", n_short, es);
            chk("rnd_long", n_long, el);
            chk("rnd_ovf", n_ovf, eo);
        end
        frame_ready = 1'b1;
        while (model.size() > 0) expq.push_back(model.pop_front());
        clks(10);
        chk("rnd_count", got.size(), expq.size());
        while (expq.size() > 0) chk_pop("rnd_data", expq.pop_front());

`ifdef SPI_ERR_CNT_EN
        // Test 6: counter saturation and clear priority
        err_clr = 1'b1;
        clks(1);
        err_clr = 1'b0;
        chk("t6_cleared", err_count, 0);
        repeat (300) send(64'h0, 0);
        chk("t6_saturate", err_count, 255);
        spi_bits(64'h5, 3);
        cs = 1'b1;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (err_short) begin lat = k; break; end
        end
        chk("t6_err_seen", lat != 0, 1);
        err_clr = 1'b1;
        clks(1);
        err_clr = 1'b0;
        chk("t6_clr_priority", err_count, 0);
        clks(5);
        chk("t6_stays_zero", err_count, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
